des_round_ctrl: RTL and testbench

//  Sequencer for the DES iterative round datapath: 16 Feistel rounds through one round

---
 rtl/des_pkg.sv | 23 ++
 rtl/des_shift_lut.sv | 27 ++
 rtl/des_round_ctrl.sv | 133 +++++++++++++
 tb/tb_des_round_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared types and constants for the DES round sequencer.
// DES_SBOX_SERIAL_EN selects the serial S-box build where it matters.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEY  = 2'd1,
    F    = 2'd2,
    DONE = 2'd3
  } state_e;

  // Bit r set: key schedule rotates by 2 in round r, else by 1.
  localparam logic [15:0] SHIFT2_MASK = 16'h7EFC;

  localparam int SBOX_SLOTS = 8;

  function automatic logic [1:0] enc_shift(
    input logic [3:0] r
  );
    return SHIFT2_MASK[r] ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/des_shift_lut.sv
// Key-rotation amount per round for encrypt and decrypt.
// Decrypt walks the schedule backwards, one round late.
module des_shift_lut
  import des_pkg::*;
(
  input  logic [3:0] round_num,
  input  logic       decrypt,
  output logic [1:0] key_shift_amt
);

  logic [3:0] rev_idx;

  // 16 - r modulo 16; r = 0 is handled separately.
  assign rev_idx = 4'd0 - round_num;

  always_comb begin
    key_shift_amt = enc_shift(round_num);
    if (decrypt) begin
      if (round_num == 4'd0) begin
        key_shift_amt = 2'd0;
      end else begin
        key_shift_amt = enc_shift(rev_idx);
      end
    end
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Round sequencer for the iterative DES datapath.
// Define DES_SBOX_SERIAL_EN for the 8-cycle shared S-box round.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int ROUNDS     = 16,
  parameter int SBOX_COUNT = SBOX_SLOTS
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       decrypt,
  output logic       load_block,
  output logic       key_shift_en,
  output logic [1:0] key_shift_amt,
  output logic       key_shift_dir,
  output logic       round_en,
  output logic [3:0] round_num,
  output logic [2:0] sbox_sel,
  output logic       sbox_capture,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       dir_q, dir_d;
  logic       f_last;
  logic [1:0] lut_amt;

`ifdef DES_SBOX_SERIAL_EN
  localparam logic [2:0] LAST_SEL = 3'(SBOX_COUNT - 1);

  logic [2:0] sel_q, sel_d;

  assign f_last       = (sel_q == LAST_SEL);
  assign sbox_sel     = sel_q;
  assign sbox_capture = (state_q == F);

  always_comb begin
    sel_d = sel_q;
    if (state_q == F) begin
      sel_d = f_last ? 3'd0 : sel_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sel_q <= 3'd0;
    end else begin
      sel_q <= sel_d;
    end
  end
`else
  assign f_last       = 1'b1;
  assign sbox_sel     = 3'd0;
  assign sbox_capture = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    dir_d        = dir_q;
    in_ready     = 1'b0;
    load_block   = 1'b0;
    key_shift_en = 1'b0;
    round_en     = 1'b0;
    out_valid    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_block = 1'b1;
          dir_d      = decrypt;
          round_d    = 4'd0;
          state_d    = KEY;
        end
      end
      KEY: begin
        key_shift_en = 1'b1;
        state_d      = F;
      end
      F: begin
        round_en = f_last;
        if (f_last) begin
          if (round_q == LAST_RND) begin
            state_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
            state_d = KEY;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      dir_q   <= dir_d;
    end
  end

  des_shift_lut u_shift_lut (
    .round_num     (round_q),
    .decrypt       (dir_q),
    .key_shift_amt (lut_amt)
  );

  assign key_shift_amt = key_shift_en ? lut_amt : 2'd0;
  assign key_shift_dir = dir_q;
  assign round_num     = round_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_des_round_ctrl.sv
// Self-checking bench for des_round_ctrl against a cycle-position model.
// Build with DES_SBOX_SERIAL_EN to exercise the serial S-box round.
module tb_des_round_ctrl;

  localparam int R = 16;
`ifdef DES_SBOX_SERIAL_EN
  localparam int P   = 9;
  localparam bit SER = 1'b1;
`else
  localparam int P   = 2;
  localparam bit SER = 1'b0;
`endif
  localparam int LAT = 1 + R * P;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       in_valid;
  logic       in_ready;
  logic       decrypt;
  logic       load_block;
  logic       key_shift_en;
  logic [1:0] key_shift_amt;
  logic       key_shift_dir;
  logic       round_en;
  logic [3:0] round_num;
  logic [2:0] sbox_sel;
  logic       sbox_capture;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  des_round_ctrl #(
    .ROUNDS     (R),
    .SBOX_COUNT (8)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .decrypt       (decrypt),
    .load_block    (load_block),
    .key_shift_en  (key_shift_en),
    .key_shift_amt (key_shift_amt),
    .key_shift_dir (key_shift_dir),
    .round_en      (round_en),
    .round_num     (round_num),
    .sbox_sel      (sbox_sel),
    .sbox_capture  (sbox_capture),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: k counts cycles since accept (k=0 is the load cycle in IDLE).
  bit m_busy;
  int m_k;
  bit m_dir;
  int m_rn;
  int cyc;
  int load_cyc;
  bit prev_ov;

  int s_tab [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic int exp_amt(input int r, input bit d);
    if (!d) return s_tab[r];
    if (r == 0) return 0;
    return s_tab[16 - r];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_k     = 0;
    m_dir   = 1'b0;
    m_rn    = 0;
    prev_ov = 1'b0;
  endtask

  task automatic step(input bit iv, input bit dec, input bit ordy);
    int e_ir, e_ld, e_ks, e_amt, e_re, e_rn, e_sel, e_cap, e_ov;
    int r, ph;
    in_valid  = iv;
    decrypt   = dec;
    out_ready = ordy;
    @(negedge clk);
    e_ir = 0; e_ld = 0; e_ks = 0; e_amt = 0; e_re = 0;
    e_rn = m_rn; e_sel = 0; e_cap = 0; e_ov = 0;
    if (!m_busy) begin
      e_ir = 1;
      e_ld = int'(iv);
    end else if (m_k < LAT) begin
      r    = (m_k - 1) / P;
      ph   = (m_k - 1) % P;
      e_rn = r;
      e_ks = (ph == 0) ? 1 : 0;
      e_re = (ph == P - 1) ? 1 : 0;
      if (SER && ph > 0) begin
        e_cap = 1;
        e_sel = ph - 1;
      end
      if (ph == 0) e_amt = exp_amt(r, m_dir);
    end else begin
      e_ov = 1;
      e_rn = R - 1;
    end
    chk("in_ready", 32'(in_ready), 32'(e_ir));
    chk("load_block", 32'(load_block), 32'(e_ld));
    chk("key_shift_en", 32'(key_shift_en), 32'(e_ks));
    chk("round_en", 32'(round_en), 32'(e_re));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("round_num", 32'(round_num), 32'(e_rn));
    chk("key_shift_dir", 32'(key_shift_dir), 32'(m_dir));
    chk("sbox_sel", 32'(sbox_sel), 32'(e_sel));
    chk("sbox_capture", 32'(sbox_capture), 32'(e_cap));
    if (e_ks != 0) chk("key_shift_amt", 32'(key_shift_amt), 32'(e_amt));
    chk("strobe_mutex",
        32'($countones({load_block, key_shift_en, round_en}) <= 1), 32'd1);
    if (out_valid && !prev_ov && m_busy) chk("latency", 32'(cyc - load_cyc), 32'(LAT));
    prev_ov = out_valid;
    if (e_ld != 0) load_cyc = cyc;
    @(posedge clk);
    cyc++;
    if (!m_busy) begin
      if (iv) begin
        m_busy = 1'b1;
        m_k    = 1;
        m_dir  = dec;
      end
    end else if (m_k < LAT) begin
      m_k++;
    end else if (ordy) begin
      m_busy = 1'b0;
      m_rn   = R - 1;
    end
    #1;
  endtask

  task automatic run_idle(input int maxc);
    int n = 0;
    while (m_busy && n < maxc) begin
      step(1'b0, 1'b0, 1'b1);
      n++;
    end
    chk("run_idle_bound", 32'(m_busy), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_strobes"}, 32'({load_block, key_shift_en, round_en, sbox_capture}), 32'd0);
    chk({tag, "_round_num"}, 32'(round_num), 32'd0);
    chk({tag, "_sbox_sel"}, 32'(sbox_sel), 32'd0);
    chk({tag, "_dir"}, 32'(key_shift_dir), 32'd0);
  endtask

  initial begin
    int n;
    n_rst     = 1'b0;
    in_valid  = 1'b0;
    decrypt   = 1'b0;
    out_ready = 1'b0;
    cyc       = 0;
    load_cyc  = 0;
    model_reset();
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // Encrypt, immediate drain
    step(1'b1, 1'b0, 1'b1);
    run_idle(LAT + 4);
    step(1'b0, 1'b0, 1'b0);

    // Decrypt
    step(1'b1, 1'b1, 1'b1);
    run_idle(LAT + 4);

    // Stall in DONE with competing in_valid
    step(1'b1, 1'b0, 1'b0);
    n = 0;
    while (m_k < LAT && n < LAT + 4) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    repeat (5) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("stall_exit_idle", 32'(m_busy), 32'd0);

    // Reset during KEY of round 7
    step(1'b1, 1'b1, 1'b1);
    n = 0;
    while (!(m_busy && m_k == 1 + 7 * P) && n < LAT + 4) begin
      step(1'b0, 1'b0, 1'b1);
      n++;
    end
    chk("reached_round7_key", 32'(m_k), 32'(1 + 7 * P));
    in_valid = 1'b0;
    n_rst    = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    run_idle(LAT + 4);

    // Back-to-back blocks
    repeat (3 * (LAT + 1) + 2) step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    run_idle(LAT + 4);

    // Random traffic
    repeat (800) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 3));
    end
    run_idle(LAT + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
